// File: rtl/inst_fetch_resp_if.sv
// Fetch-side and memory-side signals of the
// instruction fetch response buffer.
interface inst_fetch_resp_if;
    logic        request_i;
    logic [31:0] instAddr_i;
    logic        abort_i;
    logic        flush_i;
    logic        dataOk_o;
    logic [31:0] inst_o;
    logic        err_o;
    logic        busy_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic [15:0] missCnt_o;

    modport slave (
        input  request_i,
        input  instAddr_i,
        input  abort_i,
        input  flush_i,
        output dataOk_o,
        output inst_o,
        output err_o,
        output busy_o,
        output mem_req_o,
        output mem_addr_o,
        input  mem_rdata_i,
        input  mem_ack_i,
        output missCnt_o
    );

    modport master (
        output request_i,
        output instAddr_i,
        output abort_i,
        output flush_i,
        input  dataOk_o,
        input  inst_o,
        input  err_o,
        input  busy_o,
        input  mem_req_o,
        input  mem_addr_o,
        output mem_rdata_i,
        output mem_ack_i,
        input  missCnt_o
    );
endinterface

// File: rtl/inst_fetch_resp.sv
// 4-entry direct-mapped instruction buffer with
// single outstanding miss to backing memory.
module inst_fetch_resp (
    input logic               clk,
    input logic               reset_n,
    inst_fetch_resp_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] data_q [4];
    logic [27:0] tag_q  [4];
    logic [3:0]  valid_q;
    logic        drop_q;

    logic        ok_q;
    logic        err_q;
    logic [31:0] inst_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic [15:0] miss_cnt_q;

    logic [1:0]  req_idx;
    logic [1:0]  fill_idx;
    logic        req_go;
    logic        req_mis;
    logic        req_hit;
    logic        req_miss;
    logic        fill;
    logic        fill_drop;

    assign req_idx   = bus.instAddr_i[3:2];
    assign fill_idx  = mem_addr_q[3:2];
    assign req_go    = (state_q == IDLE) && bus.request_i
                       && !bus.abort_i;
    assign req_mis   = req_go && (bus.instAddr_i[1:0] != 2'b00);
    assign req_hit   = req_go && !req_mis && !bus.flush_i
                       && valid_q[req_idx]
                       && (tag_q[req_idx] == bus.instAddr_i[31:4]);
    assign req_miss  = req_go && !req_mis && !req_hit;
    assign fill      = (state_q == MISS) && bus.mem_ack_i;
    assign fill_drop = drop_q || bus.abort_i;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_miss) state_d = MISS;
            MISS: if (fill) state_d = fill_drop ? IDLE : RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered response and memory request outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            inst_q     <= 32'h0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            miss_cnt_q <= 16'h0;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            if (req_mis) begin
                ok_q   <= 1'b1;
                err_q  <= 1'b1;
                inst_q <= 32'h0;
            end else if (req_hit) begin
                ok_q   <= 1'b1;
                inst_q <= data_q[req_idx];
            end
            if (req_miss) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= {bus.instAddr_i[31:2], 2'b00};
            end
            if (fill) begin
                mem_req_q  <= 1'b0;
                miss_cnt_q <= miss_cnt_q + 16'd1;
                if (!fill_drop) begin
                    ok_q   <= 1'b1;
                    inst_q <= bus.mem_rdata_i;
                end
            end
        end
    end

    // Valid bits: flush beats a same-cycle fill.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 4'h0;
        end else if (bus.flush_i) begin
            valid_q <= 4'h0;
        end else if (fill) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Drop flag: remembers an abort while the miss is outstanding.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_q <= 1'b0;
        end else if (state_q == MISS) begin
            if (fill) begin
                drop_q <= 1'b0;
            end else if (bus.abort_i) begin
                drop_q <= 1'b1;
            end
        end else begin
            drop_q <= 1'b0;
        end
    end

    // Buffer data and tags are written on fill, never reset.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[fill_idx] <= bus.mem_rdata_i;
            tag_q[fill_idx]  <= mem_addr_q[31:4];
        end
    end

    assign bus.dataOk_o   = ok_q;
    assign bus.err_o      = err_q;
    assign bus.inst_o     = inst_q;
    assign bus.mem_req_o  = mem_req_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.missCnt_o  = miss_cnt_q;
    assign bus.busy_o     = (state_q == MISS) || (state_q == RESP);

endmodule
